mem_stall_ctrl: RTL and testbench
=================================

Name: mem_stall_ctrl

Overview:
- Sequences every MEM-stage data access onto a multi-cycle data memory using a req/ack handshake.
- Generates the single `stall_o` that freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB (their `stall_i` inputs) for the whole access.
- Returns registered read data to the MEM/WB register.
- Sits between the EX/MEM pipeline register outputs and the data memory port.

Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, data width
- TIMEOUT_CYC, 256, cycles in REQ without ack before abort (used only with MEM_TIMEOUT_EN)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-low
- Memory_read_i  in  1  MEM-stage load (EX/MEM Memory_read output)
- Memory_write_i  in  1  MEM-stage store (EX/MEM Memory_write output)
- addr_i  in  ADDR_W  access address (EX/MEM Data1 output)
- wdata_i  in  DATA_W  store data (EX/MEM forwarded-data output)
- mem_ack_i  in  1  memory completion strobe
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
- mem_req_o  out  1  access request to memory
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  ADDR_W  latched address
- mem_wdata_o  out  DATA_W  latched store data
- stall_o  out  1  pipeline-wide stall
- rdata_o  out  DATA_W  load result to MEM/WB
- done_o  out  1  one-cycle access-complete pulse
- err_o  out  1  one-cycle timeout pulse

Behaviour:
- FSM states: IDLE, REQ, DONE.
- Reset (rst_i == 0 at posedge) forces:
  - state to IDLE
  - mem_req_o, mem_we_o, done_o, err_o to 0
  - mem_addr_o, mem_wdata_o, rdata_o to 0
- Reset mid-access abandons the access: mem_req_o drops at that edge and no done_o is issued.
- IDLE:
  - If (Memory_read_i | Memory_write_i), latch addr_i, wdata_i and we = Memory_write_i; next state is REQ.
  - When both read and write are high, the write wins (mem_we_o = 1).
- REQ:
  - mem_req_o = 1; mem_addr_o, mem_wdata_o and mem_we_o are held stable.
  - On mem_ack_i: next state is DONE. If the access is a read, rdata_o <= mem_rdata_i at the same edge.
  - mem_ack_i in the first REQ cycle is legal.
- DONE:
  - mem_req_o = 0, done_o = 1 for exactly one cycle, then IDLE unconditionally.
  - Memory_read_i/Memory_write_i are ignored in DONE: the same instruction is still in EX/MEM and leaves at this edge.
- stall_o is combinational: (IDLE & (Memory_read_i | Memory_write_i)) | REQ. It is 0 in DONE, so the pipeline advances at the end of DONE.
- Minimum stall is 2 cycles (detect plus REQ with immediate ack). Each extra ack-wait cycle adds 1.
- Back-to-back accesses: the instruction arriving in MEM after DONE is detected in the IDLE cycle that follows. This gives 1 bubble-free IDLE-detect cycle per access.
- mem_ack_i outside REQ is ignored. mem_rdata_i is sampled only on ack in REQ with we = 0.
- rdata_o holds its value until the next read completes; writes leave it unchanged.
- No arithmetic is performed; all widths pass straight through.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A clog2(TIMEOUT_CYC+1)-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYC-1 with no ack, the next state is DONE with err_o = 1 alongside done_o, and rdata_o <= 0 if the access was a read.
  - Ack in the same cycle as the timeout wins: normal completion, err_o = 0.
- Undefined: no counter; REQ waits indefinitely; err_o is tied 0.

Decomposition:
- Shared package pipe_pkg holds:
  - the state typedef (IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2)
  - default ADDR_W/DATA_W constants
  - the default TIMEOUT_CYC constant
- One natural sub-module, mem_timeout_cnt: the watchdog counter with clear/enable/expire, instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- Load, immediate ack:
  - Stimulus: read at addr 0x10; mem_ack_i high in first REQ cycle with rdata 0xDEADBEEF.
  - Response: stall_o high 2 cycles; done_o pulses in cycle 3; rdata_o = 0xDEADBEEF.
- Store with 3 wait cycles:
  - Stimulus: write 0x1234 to 0x20; ack after 3 REQ cycles.
  - Response: mem_we_o = 1; addr/wdata stable throughout REQ; stall_o high 5 cycles; rdata_o unchanged.
- Simultaneous read and write:
  - Stimulus: both Memory_read_i and Memory_write_i high.
  - Response: mem_we_o = 1.
- Stray ack and back-to-back access:
  - Stimulus: ack while IDLE; then two back-to-back loads.
  - Response: stray ack ignored; DONE not re-triggered; second load starts in the IDLE after DONE.
- Reset mid-access:
  - Stimulus: rst_i low during REQ cycle 2.
  - Response: next edge mem_req_o = 0, stall_o = 0, state IDLE, no done_o.
- Timeout (MEM_TIMEOUT_EN defined, TIMEOUT_CYC = 4):
  - Stimulus: no ack.
  - Response: err_o and done_o pulse after 4 REQ cycles; rdata_o = 0.
- Timeout race (same configuration):
  - Stimulus: ack in REQ cycle 4.
  - Response: err_o = 0; normal completion.

Source files
------------

// File: rtl/mem_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the MEM-stage stall controller:
//   - state_e     : controller FSM encoding (IDLE / REQ / DONE)
//   - ADDR_W_C    : default memory address width
//   - DATA_W_C    : default data width
//   - TIMEOUT_CYC_C : default watchdog limit (used only with MEM_TIMEOUT_EN)
//   - is_access() : true when the MEM-stage instruction touches data memory
// -----------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned ADDR_W_C      = 32'd32;
  localparam int unsigned DATA_W_C      = 32'd32;
  localparam int unsigned TIMEOUT_CYC_C = 32'd256;

  function automatic logic is_access(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/mem_stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_stall_ctrl_if
// Data-memory handshake bundle between the stall controller and the memory.
//   mem_req_o   : access request (controller -> memory)
//   mem_we_o    : 1 = write, 0 = read (controller -> memory)
//   mem_addr_o  : latched address (controller -> memory)
//   mem_wdata_o : latched store data (controller -> memory)
//   mem_ack_i   : completion strobe (memory -> controller)
//   mem_rdata_i : read data, valid with mem_ack_i (memory -> controller)
// Modports: master = controller side, slave = memory side.
// -----------------------------------------------------------------------------
interface mem_stall_ctrl_if
  import pipe_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_C,
  parameter int unsigned DATA_W = DATA_W_C
);

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );

endinterface

// File: rtl/mem_stall_ctrl_timeout_cnt.sv
// -----------------------------------------------------------------------------
// mem_timeout_cnt
// Watchdog for an outstanding memory request. Only built when the macro
// MEM_TIMEOUT_EN is defined.
//   clk_i    : clock
//   rst_i    : synchronous active-low reset
//   clr_i    : restart the count (entry into REQ)
//   en_i     : count one more ack-less REQ cycle
//   expire_o : count has reached TIMEOUT_CYC-1
// -----------------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
module mem_timeout_cnt
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_C
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 32'd1);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TIMEOUT_CYC - 32'd1);

  logic [CNT_W-1:0] cnt_r;

  // Count ack-less REQ cycles, saturating at the expiry value.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_r <= '0;
    end else if (clr_i) begin
      cnt_r <= '0;
    end else if (en_i && (cnt_r != LAST_C)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire_o = (cnt_r == LAST_C);

endmodule
`endif

// File: rtl/mem_stall_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stall_ctrl
// Sequences MEM-stage loads/stores onto a multi-cycle data memory and holds
// the whole pipeline (PC .. MEM/WB) with stall_o until the access completes.
// Optional watchdog abort is enabled with the macro MEM_TIMEOUT_EN.
//   clk_i          : clock
//   rst_i          : synchronous active-low reset
//   Memory_read_i  : MEM-stage load
//   Memory_write_i : MEM-stage store (wins over a simultaneous load)
//   addr_i         : access address
//   wdata_i        : store data
//   mem            : memory handshake (mem_stall_ctrl_if.master)
//   stall_o        : pipeline-wide stall (combinational)
//   rdata_o        : registered load result to MEM/WB
//   done_o         : one-cycle access-complete pulse
//   err_o          : one-cycle timeout pulse (0 unless MEM_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module mem_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_C,
  parameter int unsigned DATA_W      = DATA_W_C,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_C
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              Memory_read_i,
  input  logic              Memory_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  mem_stall_ctrl_if.master  mem,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              done_o,
  output logic              err_o
);

  state_e            state_r, state_nxt_s;
  logic              access_s, start_s, complete_s, expire_s, timeout_s;
  logic              stall_s, req_nxt_s, done_nxt_s, err_nxt_s;
  logic              req_r, we_r, done_r, err_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r, rdata_r;

  assign access_s   = is_access(Memory_read_i, Memory_write_i);
  assign start_s    = (state_r == IDLE) && access_s;
  assign complete_s = (state_r == REQ) && mem.mem_ack_i;
  // Ack in the expiry cycle takes priority over the abort.
  assign expire_s   = (state_r == REQ) && !mem.mem_ack_i && timeout_s;

`ifdef MEM_TIMEOUT_EN
  mem_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (start_s),
    .en_i     ((state_r == REQ) && !mem.mem_ack_i),
    .expire_o (timeout_s)
  );
`else
  logic [31:0] unused_timeout_s;
  assign unused_timeout_s = TIMEOUT_CYC;
  assign timeout_s        = 1'b0;
`endif

  // State register plus the registered handshake/status outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
      req_r   <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      req_r   <= req_nxt_s;
      done_r  <= done_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  // Next-state logic; DONE always returns to IDLE because the instruction
  // that was served leaves EX/MEM at that edge.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = access_s ? REQ : IDLE;
      REQ:     state_nxt_s = (complete_s || expire_s) ? DONE : REQ;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode: stall_o combinational, the rest precomputed for registering.
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      IDLE:    stall_s = access_s;
      REQ:     stall_s = 1'b1;
      DONE:    stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
    req_nxt_s  = (state_nxt_s == REQ);
    done_nxt_s = (state_nxt_s == DONE);
    err_nxt_s  = expire_s;
  end

  // Request attributes latched at detect; load data captured on completion.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
    end else begin
      if (start_s) begin
        we_r    <= Memory_write_i;
        addr_r  <= addr_i;
        wdata_r <= wdata_i;
      end else begin
        we_r    <= we_r;
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
      end
      if (complete_s && !we_r) begin
        rdata_r <= mem.mem_rdata_i;
      end else if (expire_s && !we_r) begin
        rdata_r <= '0;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign mem.mem_req_o   = req_r;
  assign mem.mem_we_o    = we_r;
  assign mem.mem_addr_o  = addr_r;
  assign mem.mem_wdata_o = wdata_r;
  assign stall_o         = stall_s;
  assign rdata_o         = rdata_r;
  assign done_o          = done_r;
  assign err_o           = err_r;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stall_ctrl
// Table-driven per-cycle vectors for the main access patterns, followed by
// hand-written sequences for reset mid-access and the wait/timeout corners.
// -----------------------------------------------------------------------------
module tb_mem_stall_ctrl;
  import pipe_pkg::*;

  localparam int unsigned AW = 32'd32;
  localparam int unsigned DW = 32'd32;
  localparam int unsigned TO = 32'd4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          rd, wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          stall_o, done_o, err_o;
  logic [DW-1:0] rdata_o;

  int tests = 0;
  int fails = 0;

  mem_stall_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  mem_stall_ctrl #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .Memory_read_i  (rd),
    .Memory_write_i (wr),
    .addr_i         (addr),
    .wdata_i        (wdata),
    .mem            (mif),
    .stall_o        (stall_o),
    .rdata_o        (rdata_o),
    .done_o         (done_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic        ack;
    logic [31:0] mrd;
    logic        stall, req, we, done;
    logic [31:0] rdata, addr_o, wdata_o;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic k, input logic [31:0] m,
                              input logic s, input logic q, input logic e, input logic dn,
                              input logic [31:0] rdv, input logic [31:0] ao,
                              input logic [31:0] wo);
    vec_t v;
    v.rd = r; v.wr = w; v.addr = a; v.wdata = d; v.ack = k; v.mrd = m;
    v.stall = s; v.req = q; v.we = e; v.done = dn;
    v.rdata = rdv; v.addr_o = ao; v.wdata_o = wo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic k, input logic [31:0] m);
    rd = r; wr = w; addr = a; wdata = d;
    mif.mem_ack_i = k; mif.mem_rdata_i = m;
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    //              rd    wr    addr        wdata       ack   mrdata        stall req   we    done  rdata         addr_o      wdata_o
    // Load, immediate ack
    vecs[0]  = mk(1'b1, 1'b0, 32'h10,     32'h0,      1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,  32'h0);
    vecs[1]  = mk(1'b1, 1'b0, 32'h10,     32'h0,      1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h10, 32'h0);
    vecs[2]  = mk(1'b1, 1'b0, 32'h10,     32'h0,      1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h10, 32'h0);
    vecs[3]  = mk(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h10, 32'h0);
    // Simultaneous read+write: write wins, rdata untouched
    vecs[4]  = mk(1'b1, 1'b1, 32'h30,     32'h55,     1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h10, 32'h0);
    vecs[5]  = mk(1'b1, 1'b1, 32'h30,     32'h55,     1'b1, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h30, 32'h55);
    vecs[6]  = mk(1'b1, 1'b1, 32'h30,     32'h55,     1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h30, 32'h55);
    vecs[7]  = mk(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h30, 32'h55);
    // Store, 3 wait cycles; inputs change during REQ to prove latching
    vecs[8]  = mk(1'b0, 1'b1, 32'h20,     32'h1234,   1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h30, 32'h55);
    vecs[9]  = mk(1'b0, 1'b1, 32'h99,     32'h9999,   1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h20, 32'h1234);
    vecs[10] = mk(1'b0, 1'b1, 32'h99,     32'h9999,   1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h20, 32'h1234);
    vecs[11] = mk(1'b0, 1'b1, 32'h99,     32'h9999,   1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h20, 32'h1234);
    vecs[12] = mk(1'b0, 1'b1, 32'h99,     32'h9999,   1'b1, 32'hBAD0BAD0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h20, 32'h1234);
    vecs[13] = mk(1'b0, 1'b1, 32'h20,     32'h1234,   1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h20, 32'h1234);
    vecs[14] = mk(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h20, 32'h1234);
    // Stray ack while IDLE
    vecs[15] = mk(1'b0, 1'b0, 32'h0,      32'h0,      1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h20, 32'h1234);
    vecs[16] = mk(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h20, 32'h1234);
    // Back-to-back loads; stray ack in DONE is ignored
    vecs[17] = mk(1'b1, 1'b0, 32'h40,     32'h0,      1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h20, 32'h1234);
    vecs[18] = mk(1'b1, 1'b0, 32'h40,     32'h0,      1'b1, 32'hA1A1A1A1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h40, 32'h0);
    vecs[19] = mk(1'b1, 1'b0, 32'h40,     32'h0,      1'b1, 32'hFFFF0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA1A1A1A1, 32'h40, 32'h0);
    vecs[20] = mk(1'b1, 1'b0, 32'h44,     32'h0,      1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'hA1A1A1A1, 32'h40, 32'h0);
    vecs[21] = mk(1'b1, 1'b0, 32'h44,     32'h0,      1'b1, 32'hB2B2B2B2, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA1A1A1A1, 32'h44, 32'h0);
    vecs[22] = mk(1'b1, 1'b0, 32'h44,     32'h0,      1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hB2B2B2B2, 32'h44, 32'h0);
    vecs[23] = mk(1'b0, 1'b0, 32'h0,      32'h0,      1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hB2B2B2B2, 32'h44, 32'h0);

    // Reset state
    tick();
    tick();
    chk("rst_req",   32'(mif.mem_req_o),  32'h0);
    chk("rst_we",    32'(mif.mem_we_o),   32'h0);
    chk("rst_addr",  mif.mem_addr_o,      32'h0);
    chk("rst_wdata", mif.mem_wdata_o,     32'h0);
    chk("rst_rdata", rdata_o,             32'h0);
    chk("rst_done",  32'(done_o),         32'h0);
    chk("rst_err",   32'(err_o),          32'h0);
    chk("rst_stall", 32'(stall_o),        32'h0);
    rst_i = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ack, vecs[i].mrd);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall_o),       32'(vecs[i].stall));
      chk($sformatf("v%0d_req", i),   32'(mif.mem_req_o), 32'(vecs[i].req));
      chk($sformatf("v%0d_we", i),    32'(mif.mem_we_o),  32'(vecs[i].we));
      chk($sformatf("v%0d_done", i),  32'(done_o),        32'(vecs[i].done));
      chk($sformatf("v%0d_err", i),   32'(err_o),         32'h0);
      chk($sformatf("v%0d_rdata", i), rdata_o,            vecs[i].rdata);
      chk($sformatf("v%0d_addr", i),  mif.mem_addr_o,     vecs[i].addr_o);
      chk($sformatf("v%0d_wdata", i), mif.mem_wdata_o,    vecs[i].wdata_o);
      tick();
    end

    // Reset asserted during REQ cycle 2 abandons the access
    drive(1'b1, 1'b0, 32'h60, 32'h0, 1'b0, 32'h0);
    #1;
    chk("ra_detect_stall", 32'(stall_o), 32'h1);
    tick();
    #1;
    chk("ra_req1", 32'(mif.mem_req_o), 32'h1);
    tick();
    rst_i = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("ra_req2", 32'(mif.mem_req_o), 32'h1);
    tick();
    chk("ra_req_dropped", 32'(mif.mem_req_o), 32'h0);
    chk("ra_stall",       32'(stall_o),       32'h0);
    chk("ra_no_done",     32'(done_o),        32'h0);
    chk("ra_addr_clr",    mif.mem_addr_o,     32'h0);
    chk("ra_rdata_clr",   rdata_o,            32'h0);
    rst_i = 1'b1;
    tick();
    chk("ra_no_done_after", 32'(done_o),        32'h0);
    chk("ra_idle_req",      32'(mif.mem_req_o), 32'h0);

`ifdef MEM_TIMEOUT_EN
    // Ack in REQ cycle 4 races the expiry: normal completion
    drive(1'b1, 1'b0, 32'h90, 32'h0, 1'b0, 32'h0);
    tick();
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk($sformatf("race_req%0d", c), 32'(mif.mem_req_o), 32'h1);
      tick();
    end
    drive(1'b1, 1'b0, 32'h90, 32'h0, 1'b1, 32'h00000077);
    #1;
    chk("race_req4", 32'(mif.mem_req_o), 32'h1);
    tick();
    drive(1'b1, 1'b0, 32'h90, 32'h0, 1'b0, 32'h0);
    #1;
    chk("race_done",  32'(done_o), 32'h1);
    chk("race_err",   32'(err_o),  32'h0);
    chk("race_rdata", rdata_o,     32'h00000077);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();

    // No ack: abort after 4 REQ cycles, load result zeroed
    drive(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0);
    tick();
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("to_req%0d", c),  32'(mif.mem_req_o), 32'h1);
      chk($sformatf("to_err%0d", c),  32'(err_o),         32'h0);
      chk($sformatf("to_done%0d", c), 32'(done_o),        32'h0);
      tick();
    end
    chk("to_done",  32'(done_o),        32'h1);
    chk("to_err",   32'(err_o),         32'h1);
    chk("to_rdata", rdata_o,            32'h0);
    chk("to_req",   32'(mif.mem_req_o), 32'h0);
    chk("to_stall", 32'(stall_o),       32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("to_err_pulse",  32'(err_o),  32'h0);
    chk("to_done_pulse", 32'(done_o), 32'h0);
`else
    // Without the watchdog a request waits indefinitely
    drive(1'b1, 1'b0, 32'h70, 32'h0, 1'b0, 32'h0);
    tick();
    for (int c = 0; c < 20; c++) begin
      #1;
      chk($sformatf("wait_req%0d", c),  32'(mif.mem_req_o), 32'h1);
      chk($sformatf("wait_done%0d", c), 32'(done_o),        32'h0);
      chk($sformatf("wait_err%0d", c),  32'(err_o),         32'h0);
      tick();
    end
    drive(1'b1, 1'b0, 32'h70, 32'h0, 1'b1, 32'h70707070);
    tick();
    drive(1'b1, 1'b0, 32'h70, 32'h0, 1'b0, 32'h0);
    #1;
    chk("wait_done",  32'(done_o), 32'h1);
    chk("wait_err",   32'(err_o),  32'h0);
    chk("wait_rdata", rdata_o,     32'h70707070);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("wait_done_pulse", 32'(done_o), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
